// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron trainer.
//   state_e  : trainer FSM states
//   DEF_*    : default parameter values used by the trainer and its lanes
//   sat_add  : add two signed values and clamp the sum to a w-bit signed range
package perceptron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_N_IN      = 2;
  localparam int DEF_XW        = 7;
  localparam int DEF_WW        = 14;
  localparam int DEF_DEPTH     = 200;
  localparam int DEF_ALPHA     = 3;
  localparam int DEF_MAX_EPOCH = 63;

  // Operands arrive sign-extended to 64 bits, so the raw sum cannot overflow
  // for any width this design is used with.
  function automatic longint sat_add(input longint a, input longint b, input int w);
    longint sum;
    longint hi;
    longint lo;
    sum = a + b;
    hi  = (longint'(1) <<< (w - 1)) - longint'(1);
    lo  = -(longint'(1) <<< (w - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/perceptron_lane.sv
// One input lane of the perceptron: forms the full-precision product x*w
// and the saturated candidate weight w + ALPHA*t*x.
//   x_i     : signed sample input (XW bits)
//   w_i     : current signed weight (WW bits)
//   t_i     : target, 1 = +1, 0 = -1
//   upd_i   : apply the learning step
//   prod_o  : signed x*w (XW+WW bits, exact)
//   w_nxt_o : next weight (w_i when upd_i is low)
module perceptron_lane
  import perceptron_pkg::*;
#(
  parameter int XW    = DEF_XW,
  parameter int WW    = DEF_WW,
  parameter int ALPHA = DEF_ALPHA
) (
  input  logic [XW-1:0]    x_i,
  input  logic [WW-1:0]    w_i,
  input  logic             t_i,
  input  logic             upd_i,
  output logic [XW+WW-1:0] prod_o,
  output logic [WW-1:0]    w_nxt_o
);

  localparam logic signed [7:0] ALPHA_S = 8'(ALPHA);

  logic signed [XW-1:0]    x_s;
  logic signed [WW-1:0]    w_s;
  logic signed [XW+WW-1:0] prod_s;
  logic signed [XW+8:0]    step_s;
  logic signed [XW+8:0]    step_t;

  assign x_s    = x_i;
  assign w_s    = w_i;
  assign prod_s = x_s * w_s;
  // 8-bit alpha times XW-bit x fits in XW+8 signed bits; one extra bit keeps
  // the negation for t=-1 exact.
  assign step_s = ALPHA_S * x_s;
  assign step_t = t_i ? step_s : -step_s;

  assign prod_o  = prod_s;
  assign w_nxt_o = upd_i ? WW'(sat_add(longint'(w_s), longint'(step_t), WW)) : w_i;

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: buffers up to DEPTH labelled samples, then on start
// sweeps them one per cycle, applying the perceptron rule, until an epoch
// makes no update or MAX_EPOCH epochs have run.
//   clk, rst        : clock, synchronous active-high reset
//   s_valid/s_ready : sample handshake; s_x packed signed inputs, s_t target
//   start           : begin (or resume) training
//   clear           : empty the buffer and zero weights and bias
//   busy            : high during every training cycle
//   done            : one-cycle pulse when training ends
//   converged       : last epoch made no update
//   epochs          : completed epochs of the last run
//   weights, bias   : current signed parameters
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int N_IN      = DEF_N_IN,
  parameter int XW        = DEF_XW,
  parameter int WW        = DEF_WW,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ALPHA     = DEF_ALPHA,
  parameter int MAX_EPOCH = DEF_MAX_EPOCH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [N_IN*XW-1:0]   s_x,
  input  logic                 s_t,
  input  logic                 start,
  input  logic                 clear,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [7:0]           epochs,
  output logic [N_IN*WW-1:0]   weights,
  output logic [WW-1:0]        bias
);

  localparam int SW = N_IN*XW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = XW + WW;
  localparam int YW = PW + $clog2(N_IN + 1) + 1;
  localparam logic signed [7:0]    ALPHA_S = 8'(ALPHA);
  localparam logic signed [YW-1:0] ZERO    = '0;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [N_IN*WW-1:0]  weights_q, weights_d;
  logic [WW-1:0]       bias_q, bias_d;
  logic [7:0]          epochs_q, epochs_d;
  logic                conv_q, conv_d;
  logic                any_upd_q, any_upd_d;
  logic                wr_en;

  logic [SW-1:0]       mem_q [DEPTH];
  logic [SW-1:0]       smp;
  logic                smp_t;
  logic [PW-1:0]       prod [N_IN];
  logic [WW-1:0]       w_nxt [N_IN];
  logic signed [YW-1:0] yin;
  logic                upd;
  logic                last;
  logic                ep_upd;
  logic [WW-1:0]       bias_nxt;

  assign smp   = mem_q[idx_q];
  assign smp_t = smp[SW-1];

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    perceptron_lane #(
      .XW    (XW),
      .WW    (WW),
      .ALPHA (ALPHA)
    ) u_lane (
      .x_i     (smp[i*XW +: XW]),
      .w_i     (weights_q[i*WW +: WW]),
      .t_i     (smp_t),
      .upd_i   (upd),
      .prod_o  (prod[i]),
      .w_nxt_o (w_nxt[i])
    );
  end

  // Net input at full precision; YW leaves headroom for the N_IN+1 terms.
  always_comb begin
    yin = YW'($signed(bias_q));
    for (int i = 0; i < N_IN; i++) begin
      yin = yin + YW'($signed(prod[i]));
    end
  end

  // yin==0 counts as misclassified for either target.
  assign upd      = smp_t ? (yin <= ZERO) : (yin >= ZERO);
  assign bias_nxt = smp_t ? WW'(sat_add(longint'($signed(bias_q)), longint'(ALPHA_S), WW))
                          : WW'(sat_add(longint'($signed(bias_q)), -longint'(ALPHA_S), WW));
  assign last     = (idx_q == count_q - CW'(1));
  assign ep_upd   = any_upd_q | upd;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    weights_d = weights_q;
    bias_d    = bias_q;
    epochs_d  = epochs_q;
    conv_d    = conv_q;
    any_upd_d = any_upd_q;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          count_d   = '0;
          weights_d = '0;
          bias_d    = '0;
        end else begin
          if (s_valid && s_ready) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end
          if (start) begin
            epochs_d  = '0;
            conv_d    = 1'b0;
            idx_d     = '0;
            any_upd_d = 1'b0;
            if (count_q == '0) begin
              // Nothing to learn: report an immediately converged run.
              conv_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = TRAIN;
            end
          end
        end
      end
      TRAIN: begin
        if (upd) begin
          for (int i = 0; i < N_IN; i++) begin
            weights_d[i*WW +: WW] = w_nxt[i];
          end
          bias_d = bias_nxt;
        end
        if (last) begin
          idx_d     = '0;
          epochs_d  = epochs_q + 8'd1;
          any_upd_d = 1'b0;
          if (!ep_upd) begin
            conv_d  = 1'b1;
            state_d = DONE;
          end else if (epochs_q == 8'(MAX_EPOCH - 1)) begin
            state_d = DONE;
          end
        end else begin
          idx_d     = idx_q + CW'(1);
          any_upd_d = ep_upd;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      weights_q <= '0;
      bias_q    <= '0;
      epochs_q  <= '0;
      conv_q    <= 1'b0;
      any_upd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      weights_q <= weights_d;
      bias_q    <= bias_d;
      epochs_q  <= epochs_d;
      conv_q    <= conv_d;
      any_upd_q <= any_upd_d;
    end
  end

  // Sample storage is pure data; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[count_q] <= {s_t, s_x};
    end
  end

  assign s_ready   = (state_q == IDLE) && (count_q < CW'(DEPTH));
  assign busy      = (state_q == TRAIN);
  assign done      = (state_q == DONE);
  assign converged = conv_q;
  assign epochs    = epochs_q;
  assign weights   = weights_q;
  assign bias      = bias_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
module tb_perceptron_trainer;

  localparam int N_IN      = 2;
  localparam int XW        = 7;
  localparam int WW        = 8;
  localparam int DEPTH     = 200;
  localparam int ALPHA     = 3;
  localparam int MAX_EPOCH = 63;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [N_IN*XW-1:0]  s_x = '0;
  logic                s_t = 1'b0;
  logic                start = 1'b0;
  logic                clear = 1'b0;
  logic                busy;
  logic                done;
  logic                converged;
  logic [7:0]          epochs;
  logic [N_IN*WW-1:0]  weights;
  logic [WW-1:0]       bias;

  perceptron_trainer #(
    .N_IN      (N_IN),
    .XW        (XW),
    .WW        (WW),
    .DEPTH     (DEPTH),
    .ALPHA     (ALPHA),
    .MAX_EPOCH (MAX_EPOCH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_x       (s_x),
    .s_t       (s_t),
    .start     (start),
    .clear     (clear),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .epochs    (epochs),
    .weights   (weights),
    .bias      (bias)
  );

  always #5 clk = ~clk;

  typedef struct {
    int busy;
    int ep;
    int conv;
    int w0;
    int w1;
    int b;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int sw(input logic [WW-1:0] v);
    logic signed [WW-1:0] s;
    s = v;
    return int'(s);
  endfunction

  // Monitor: counts training cycles and scores each run when done pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt  = 0;
        prev_done = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          chk("done_pulse_width", int'(prev_done), 0);
          if (exp_q.size() == 0) begin
            chk("exp_queue_on_done", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("busy_cycles", busy_cnt, e.busy);
            chk("epochs", int'(epochs), e.ep);
            chk("converged", int'(converged), e.conv);
            chk("w0", sw(weights[WW-1:0]), e.w0);
            chk("w1", sw(weights[2*WW-1:WW]), e.w1);
            chk("bias", sw(bias), e.b);
          end
          busy_cnt = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic push(input int x0, input int x1, input logic t, output logic acc);
    s_valid = 1'b1;
    s_x     = {XW'(x1), XW'(x0)};
    s_t     = t;
    acc     = s_ready;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int tgt;
    tgt = done_cnt + 1;
    for (int n = 0; n < budget && done_cnt < tgt; n++) @(posedge clk);
    #1;
    chk("done_seen", done_cnt, tgt);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_s_ready"}, int'(s_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_converged"}, int'(converged), 0);
    chk({tag, "_epochs"}, int'(epochs), 0);
    chk({tag, "_weights"}, int'(weights), 0);
    chk({tag, "_bias"}, int'(bias), 0);
  endtask

  task automatic load_and();
    logic a;
    push( 1,  1, 1'b1, a);
    push( 1, -1, 1'b0, a);
    push(-1,  1, 1'b0, a);
    push(-1, -1, 1'b0, a);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic a;
    int   acc_n;
    int   rej_n;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // Bipolar AND
    load_and();
    exp_q.push_back('{8, 2, 1, 3, 3, -3});
    pulse_start();
    wait_done(100);
    chk("and_epochs_hold", int'(epochs), 2);
    chk("and_conv_hold", int'(converged), 1);
    chk("and_idle_ready", int'(s_ready), 1);

    // Weight saturation at WW=8: 3*63 = 189 clamps to 127
    pulse_clear();
    push(63, 0, 1'b1, a);
    exp_q.push_back('{2, 2, 1, 127, 0, 3});
    pulse_start();
    wait_done(50);

    // XOR never separates; weights return to zero every epoch
    pulse_clear();
    push( 1,  1, 1'b0, a);
    push( 1, -1, 1'b1, a);
    push(-1,  1, 1'b1, a);
    push(-1, -1, 1'b0, a);
    exp_q.push_back('{MAX_EPOCH*4, MAX_EPOCH, 0, 0, 0, 0});
    pulse_start();
    wait_done(400);

    // Buffer full: the 5 conflicting extra samples must be dropped
    pulse_clear();
    acc_n = 0;
    rej_n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      push(1, 1, 1'b1, a);
      if (a) acc_n++;
    end
    chk("full_s_ready", int'(s_ready), 0);
    for (int i = 0; i < 5; i++) begin
      push(1, 1, 1'b0, a);
      if (!a) rej_n++;
    end
    chk("full_accepted", acc_n, DEPTH);
    chk("full_rejected", rej_n, 5);
    exp_q.push_back('{2*DEPTH, 2, 1, 3, 3, 3});
    pulse_start();
    wait_done(2*DEPTH + 50);

    // Reset in the middle of training, then rerun AND
    pulse_clear();
    load_and();
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("midrst");
    load_and();
    exp_q.push_back('{8, 2, 1, 3, 3, -3});
    pulse_start();
    wait_done(100);

    // Start with an empty buffer
    pulse_clear();
    exp_q.push_back('{0, 0, 1, 0, 0, 0});
    pulse_start();
    wait_done(10);

    chk("exp_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
